// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controllers: FSM state encoding and legal WIDTH range.
// The optional subtract feature is enabled in the controller by defining SERIAL_ADD_SUB_EN.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit widthIsLegal(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the serial adder controller (slave).
// The sub select is present only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_mux_cell.sv
// One-bit full adder built only from two 4:1 multiplexers selected by {cin, b}.
// The operand a (or its inverse) is steered to the outputs, so no XOR/majority gates are needed.
module fa_mux_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic [1:0] w_sel;

    assign w_sel = {cin, b};

    // sum mux legs: a, ~a, ~a, a ; carry mux legs: 0, a, a, 1
    always_comb begin
        sum  = a;
        cout = 1'b0;
        case (w_sel)
            2'b00: begin
                sum  = a;
                cout = 1'b0;
            end
            2'b01: begin
                sum  = ~a;
                cout = a;
            end
            2'b10: begin
                sum  = ~a;
                cout = a;
            end
            2'b11: begin
                sum  = a;
                cout = 1'b1;
            end
            default: begin
                sum  = a;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one shared fa_mux_cell over WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub select (a - b via ~b and carry-in of 1).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    serial_state_t    r_state;
    serial_state_t    w_nextState;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             w_capture;
    logic             w_shift;
    logic [WIDTH-1:0] w_loadB;
    logic             w_loadC;
    logic             w_faSum;
    logic             w_faCout;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored when sub is selected.
    assign w_loadB = bus.sub ? ~bus.b : bus.b;
    assign w_loadC = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_loadB = bus.b;
    assign w_loadC = bus.cin;
`endif

    fa_mux_cell u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_c),
        .sum  (w_faSum),
        .cout (w_faCout)
    );

    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_capture   = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                // A start here restarts immediately so held-start streams have no idle gap.
                if (bus.start) begin
                    w_capture   = 1'b1;
                    w_nextState = RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_sum <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (w_capture) begin
            r_sa  <= bus.a;
            r_sb  <= w_loadB;
            r_sum <= '0;
            r_c   <= w_loadC;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
            r_sum <= {w_faSum, r_sum[WIDTH-1:1]};
            r_c   <= w_faCout;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_c;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed vectors push expected results,
// a negedge monitor pops and checks them when done is seen.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               doneCycle;
        string            name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycleCnt;
    int   assertCount;
    int   failCount;
    exp_t expQ[$];

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cycleCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycleCnt);
        end
    endtask

    // Inputs change at negedge; the capture edge number sets the expected done cycle.
    task automatic applyStimulus(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub,
                                 input logic [WIDTH-1:0] expSum, input logic expCout);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("[TB] note: sub ignored in add-only build");
`endif
        @(posedge clk);
        #1;
        e.sum       = expSum;
        e.cout      = expCout;
        e.doneCycle = cycleCnt + WIDTH;
        e.name      = name;
        expQ.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDrained(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_drain"}, expQ.size(), 0);
        expQ.delete();
    endtask

    // Monitor: every done must match the head of the scoreboard, on the predicted cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.busy && bus.done) begin
                checkOutput("busy_done_overlap", 1, 0);
            end
            if (bus.done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, "_sum"},   bus.sum,  e.sum);
                    checkOutput({e.name, "_cout"},  bus.cout, e.cout);
                    checkOutput({e.name, "_cycle"}, cycleCnt, e.doneCycle);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int capCycle;
        exp_t e;
        cycleCnt    = 0;
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.cin     = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_sum",  bus.sum,  0);
        checkOutput("reset_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic add with busy window: high for 8 sampled cycles, then low when done.
        applyStimulus("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("busy_window_%0d", i), bus.busy, (i < 8) ? 1 : 0);
            @(negedge clk);
        end
        waitDrained("add_5a_3c");

        applyStimulus("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        waitDrained("add_ff_01");
        applyStimulus("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        waitDrained("add_ff_ff_c1");
        applyStimulus("add_00_00_c1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        waitDrained("add_00_00_c1");

        // Start during RUN and operand changes must be ignored.
        applyStimulus("busy_start", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        waitDrained("busy_start");
        repeat (3) @(negedge clk);

        // Back-to-back with start held: second capture happens in the DONE cycle.
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        capCycle = cycleCnt;
        e.sum = 8'h10; e.cout = 1'b0; e.doneCycle = capCycle + WIDTH;     e.name = "b2b_first";
        expQ.push_back(e);
        e.sum = 8'h00; e.cout = 1'b1; e.doneCycle = capCycle + 2 * WIDTH + 1; e.name = "b2b_second";
        expQ.push_back(e);
        @(negedge clk);
        bus.a = 8'h80;
        bus.b = 8'h80;
        while (cycleCnt < capCycle + WIDTH + 1) @(negedge clk);
        bus.start = 1'b0;
        waitDrained("b2b");
        repeat (3) @(negedge clk);

        // Reset mid-RUN discards the partial result; any later done is flagged by the monitor.
        applyStimulus("mid_reset", 8'h0F, 8'h0F, 1'b0, 1'b0, 8'h1E, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1;
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        checkOutput("midrst_sum",  bus.sum,  0);
        checkOutput("midrst_cout", bus.cout, 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        applyStimulus("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        waitDrained("sub_10_01");
        applyStimulus("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        waitDrained("sub_01_02");
        applyStimulus("sub0_add", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        waitDrained("sub0_add");
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
